// File: rtl/ram_port_arbiter_if.sv
// Request/response and RAM-side signal bundle for ram_port_arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface ram_port_arbiter_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 16,
   parameter int N_REQ  = 2
);
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_we;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_wdata;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]       rsp_data;
   logic [ADDR_W-1:0]       ram_ra;
   logic [ADDR_W-1:0]       ram_wa;
   logic [DATA_W-1:0]       ram_data;
   logic                    ram_we;
   logic [DATA_W-1:0]       ram_result;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, ram_result,
      output req_ready, rsp_valid, rsp_data, ram_ra, ram_wa, ram_data, ram_we
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, ram_result,
      input  req_ready, rsp_valid, rsp_data, ram_ra, ram_wa, ram_data, ram_we
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of a 1R/1W RAM; grants are combinational, read data returns one cycle
// after grant with write-first forwarding on same-address collisions; responses take no backpressure.
module ram_port_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 16,
   parameter int N_REQ  = 2,
   parameter int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic               clk,
   input  logic               reset_n,
   ram_port_arbiter_if.slave  bus
);
   logic [ID_W-1:0]   rd_ptr, wr_ptr;
   logic [ID_W-1:0]   rd_win, wr_win;
   logic [ID_W-1:0]   rd_idx, wr_idx;
   logic              rd_gnt, wr_gnt;
   logic [N_REQ-1:0]  rd_oh, wr_oh;
   logic              fwd_hit;
   logic              fwd_flag;
   logic [DATA_W-1:0] fwd_data;

   // Scan from each pointer; first candidate found wins.
   always_comb begin
      rd_gnt = 1'b0;
      wr_gnt = 1'b0;
      rd_win = '0;
      wr_win = '0;
      rd_idx = '0;
      wr_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         rd_idx = ID_W'((int'(rd_ptr) + k) % N_REQ);
         wr_idx = ID_W'((int'(wr_ptr) + k) % N_REQ);
         if (!rd_gnt && bus.req_valid[rd_idx] && !bus.req_we[rd_idx]) begin
            rd_gnt = 1'b1;
            rd_win = rd_idx;
         end
         if (!wr_gnt && bus.req_valid[wr_idx] && bus.req_we[wr_idx]) begin
            wr_gnt = 1'b1;
            wr_win = wr_idx;
         end
      end
   end

   assign rd_oh = rd_gnt ? (N_REQ'(1) << rd_win) : '0;
   assign wr_oh = wr_gnt ? (N_REQ'(1) << wr_win) : '0;

   assign bus.req_ready = rd_oh | wr_oh;
   assign bus.ram_we    = wr_gnt;
   assign bus.ram_wa    = wr_gnt ? bus.req_addr[wr_win*ADDR_W +: ADDR_W]  : '0;
   assign bus.ram_data  = wr_gnt ? bus.req_wdata[wr_win*DATA_W +: DATA_W] : '0;
   assign bus.ram_ra    = rd_gnt ? bus.req_addr[rd_win*ADDR_W +: ADDR_W]  : '0;

   // The RAM returns pre-write data on a same-cycle collision, so capture the write instead.
   assign fwd_hit = rd_gnt && wr_gnt && (bus.ram_ra == bus.ram_wa);

   assign bus.rsp_data = fwd_flag         ? fwd_data       :
                         (|bus.rsp_valid) ? bus.ram_result : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         bus.rsp_valid <= '0;
         fwd_flag      <= 1'b0;
         fwd_data      <= '0;
      end else begin
         if (rd_gnt)
            rd_ptr <= (rd_win == ID_W'(N_REQ - 1)) ? '0 : rd_win + 1'b1;
         if (wr_gnt)
            wr_ptr <= (wr_win == ID_W'(N_REQ - 1)) ? '0 : wr_win + 1'b1;
         bus.rsp_valid <= rd_oh;
         fwd_flag      <= fwd_hit;
         if (fwd_hit)
            fwd_data <= bus.ram_data;
      end
   end
endmodule
